// File: rtl/regfile_2r1w.sv
// regfile_2r1w: DEPTH x WIDTH register file with one write port and two registered read ports.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to reads of the written address.
module regfile_2r1w #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en_1,
  input  logic [ADDR_W-1:0] rd_addr_1,
  output logic [WIDTH-1:0]  rd_data_1,
  output logic              rd_valid_1,
  input  logic              rd_en_2,
  input  logic [ADDR_W-1:0] rd_addr_2,
  output logic [WIDTH-1:0]  rd_data_2,
  output logic              rd_valid_2,
  output logic              addr_err
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [WIDTH-1:0] rd_next_1_s;
  logic [WIDTH-1:0] rd_next_2_s;
  logic             wr_ok_s;
  logic             rd_ok_1_s;
  logic             rd_ok_2_s;
  logic             fwd_1_s;
  logic             fwd_2_s;
  logic             err_set_s;

  // DEPTH need not be a power of two, so the top of the address space may be unmapped.
  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return (32'(addr) < 32'(DEPTH));
  endfunction

  assign wr_ok_s   = in_range(wr_addr);
  assign rd_ok_1_s = in_range(rd_addr_1);
  assign rd_ok_2_s = in_range(rd_addr_2);
  assign err_set_s = (wr_en & ~wr_ok_s) | (rd_en_1 & ~rd_ok_1_s) | (rd_en_2 & ~rd_ok_2_s);

`ifdef REGFILE_BYPASS_EN
  assign fwd_1_s = wr_en & ~clr & (wr_addr == rd_addr_1);
  assign fwd_2_s = wr_en & ~clr & (wr_addr == rd_addr_2);
`else
  assign fwd_1_s = 1'b0;
  assign fwd_2_s = 1'b0;
`endif

  // Read-data selection; out-of-range reads return zero rather than X.
  always_comb begin
    rd_next_1_s = {WIDTH{1'b0}};
    if (!rd_ok_1_s) begin
      rd_next_1_s = {WIDTH{1'b0}};
    end else if (fwd_1_s) begin
      rd_next_1_s = wr_data;
    end else begin
      rd_next_1_s = mem_r[rd_addr_1];
    end
  end

  // Read-data selection for port 2.
  always_comb begin
    rd_next_2_s = {WIDTH{1'b0}};
    if (!rd_ok_2_s) begin
      rd_next_2_s = {WIDTH{1'b0}};
    end else if (fwd_2_s) begin
      rd_next_2_s = wr_data;
    end else begin
      rd_next_2_s = mem_r[rd_addr_2];
    end
  end

  // Storage array: clr wins over a simultaneous write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= {WIDTH{1'b0}};
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= {WIDTH{1'b0}};
    end else if (wr_en && wr_ok_s) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Read output registers; data holds when its port is idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data_1  <= {WIDTH{1'b0}};
      rd_data_2  <= {WIDTH{1'b0}};
      rd_valid_1 <= 1'b0;
      rd_valid_2 <= 1'b0;
    end else begin
      rd_valid_1 <= rd_en_1;
      rd_valid_2 <= rd_en_2;
      if (rd_en_1) rd_data_1 <= rd_next_1_s;
      if (rd_en_2) rd_data_2 <= rd_next_2_s;
    end
  end

  // Sticky out-of-range flag, cleared only by reset or clr.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_err <= 1'b0;
    end else if (clr) begin
      addr_err <= 1'b0;
    end else if (err_set_s) begin
      addr_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_2r1w.sv
// Randomized + directed bench for regfile_2r1w (DEPTH=6 so out-of-range addresses exist).
// Honours REGFILE_BYPASS_EN in its reference model.
module tb_regfile_2r1w;

  localparam int WIDTH  = 16;
  localparam int DEPTH  = 6;
  localparam int ADDR_W = 3;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk;
  logic              reset;
  logic              clr;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic              rd_en_1;
  logic [ADDR_W-1:0] rd_addr_1;
  logic [WIDTH-1:0]  rd_data_1;
  logic              rd_valid_1;
  logic              rd_en_2;
  logic [ADDR_W-1:0] rd_addr_2;
  logic [WIDTH-1:0]  rd_data_2;
  logic              rd_valid_2;
  logic              addr_err;

  regfile_2r1w #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .clr(clr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en_1(rd_en_1), .rd_addr_1(rd_addr_1), .rd_data_1(rd_data_1), .rd_valid_1(rd_valid_1),
    .rd_en_2(rd_en_2), .rd_addr_2(rd_addr_2), .rd_data_2(rd_data_2), .rd_valid_2(rd_valid_2),
    .addr_err(addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference state
  logic [WIDTH-1:0] m_mem [8];
  logic [WIDTH-1:0] exp_d1, exp_d2;
  logic             exp_v1, exp_v2, exp_err;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_mem[i] = 16'h0000;
    exp_d1 = 16'h0000; exp_d2 = 16'h0000;
    exp_v1 = 1'b0; exp_v2 = 1'b0; exp_err = 1'b0;
  endtask

  function automatic logic [WIDTH-1:0] model_read(input int a, input logic we, input int wa,
                                                  input logic [WIDTH-1:0] wd, input logic cl);
    if (a >= DEPTH) return 16'h0000;
    if (BYP && we && !cl && a == wa) return wd;
    return m_mem[a];
  endfunction

  task automatic check_outputs(input string tag);
    check_eq({tag, ".d1"}, 32'(rd_data_1), 32'(exp_d1));
    check_eq({tag, ".v1"}, 32'(rd_valid_1), 32'(exp_v1));
    check_eq({tag, ".d2"}, 32'(rd_data_2), 32'(exp_d2));
    check_eq({tag, ".v2"}, 32'(rd_valid_2), 32'(exp_v2));
    check_eq({tag, ".err"}, 32'(addr_err), 32'(exp_err));
  endtask

  // One clock: drive at negedge, predict, check #1 after posedge, return at next negedge.
  task automatic step(input string tag, input logic we, input int wa, input logic [WIDTH-1:0] wd,
                      input logic re1, input int ra1, input logic re2, input int ra2, input logic cl);
    wr_en = we; wr_addr = 3'(wa); wr_data = wd;
    rd_en_1 = re1; rd_addr_1 = 3'(ra1);
    rd_en_2 = re2; rd_addr_2 = 3'(ra2);
    clr = cl;
    if (re1) exp_d1 = model_read(ra1, we, wa, wd, cl);
    if (re2) exp_d2 = model_read(ra2, we, wa, wd, cl);
    exp_v1 = re1;
    exp_v2 = re2;
    if (cl) begin
      exp_err = 1'b0;
      for (int i = 0; i < 8; i++) m_mem[i] = 16'h0000;
    end else begin
      if ((we && wa >= DEPTH) || (re1 && ra1 >= DEPTH) || (re2 && ra2 >= DEPTH)) exp_err = 1'b1;
      if (we && wa < DEPTH) m_mem[wa] = wd;
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; clr = 1'b0; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 16'h0000;
    rd_en_1 = 1'b0; rd_addr_1 = 3'd0; rd_en_2 = 1'b0; rd_addr_2 = 3'd0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs("rst");
    reset = 1'b1;

    // reset contents at both ends of the range
    step("rd0", 1'b0, 0, 16'h0, 1'b1, 0, 1'b1, DEPTH-1, 1'b0);
    step("idle0", 1'b0, 0, 16'h0, 1'b0, 0, 1'b0, 0, 1'b0);

    step("wr3", 1'b1, 3, 16'hA5A5, 1'b0, 0, 1'b0, 0, 1'b0);
    step("wr5", 1'b1, 5, 16'h1234, 1'b0, 0, 1'b0, 0, 1'b0);
    step("rd35", 1'b0, 0, 16'h0, 1'b1, 3, 1'b1, 5, 1'b0);
    check_eq("rd3_lit", 32'(rd_data_1), 32'h0000A5A5);
    check_eq("rd5_lit", 32'(rd_data_2), 32'h00001234);
    step("hold", 1'b0, 0, 16'h0, 1'b0, 0, 1'b0, 0, 1'b0);

    // same-cycle write/read collision
    step("wr2", 1'b1, 2, 16'h0001, 1'b0, 0, 1'b0, 0, 1'b0);
    step("coll", 1'b1, 2, 16'hBEEF, 1'b1, 2, 1'b0, 0, 1'b0);
    check_eq("coll_lit", 32'(rd_data_1), BYP ? 32'h0000BEEF : 32'h00000001);
    step("after", 1'b0, 0, 16'h0, 1'b1, 2, 1'b1, 2, 1'b0);
    check_eq("after_lit", 32'(rd_data_2), 32'h0000BEEF);

    // out-of-range write and read, sticky flag, then clr
    step("oorw", 1'b1, 7, 16'hFFFF, 1'b0, 0, 1'b0, 0, 1'b0);
    step("oorr", 1'b0, 0, 16'h0, 1'b1, 7, 1'b1, DEPTH, 1'b0);
    step("sticky", 1'b0, 0, 16'h0, 1'b1, 3, 1'b0, 0, 1'b0);
    step("clr", 1'b0, 0, 16'h0, 1'b1, 5, 1'b0, 0, 1'b1);
    for (int a = 0; a < DEPTH; a++) step("clrd", 1'b0, 0, 16'h0, 1'b1, a, 1'b1, DEPTH-1-a, 1'b0);

    // clr beats a simultaneous write
    step("clrwr", 1'b1, 1, 16'h5555, 1'b1, 1, 1'b0, 0, 1'b1);
    step("clrwr_rd", 1'b0, 0, 16'h0, 1'b0, 0, 1'b1, 1, 1'b0);
    check_eq("clrwr_lit", 32'(rd_data_2), 32'h00000000);

    // async reset mid-cycle with a read in flight on port 2
    for (int a = 0; a < DEPTH; a++) step("fill", 1'b1, a, 16'(16'h1111 * (a + 1)), 1'b0, 0, 1'b0, 0, 1'b0);
    step("pre", 1'b0, 0, 16'h0, 1'b1, 4, 1'b1, 4, 1'b0);
    wr_en = 1'b0; rd_en_1 = 1'b0; rd_en_2 = 1'b1; rd_addr_2 = 3'd4;
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_outputs("arst");
    @(posedge clk);
    #1;
    check_outputs("arst_edge");
    @(negedge clk);
    rd_en_2 = 1'b0;
    reset = 1'b1;
    step("post", 1'b0, 0, 16'h0, 1'b0, 0, 1'b0, 0, 1'b0);
    for (int a = 0; a < DEPTH; a++) step("postrd", 1'b0, 0, 16'h0, 1'b1, a, 1'b1, a, 1'b0);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic we, re1, re2, cl;
      int wa, ra1, ra2;
      we  = ($urandom_range(0, 1) == 1);
      re1 = ($urandom_range(0, 9) < 7);
      re2 = ($urandom_range(0, 9) < 7);
      cl  = ($urandom_range(0, 39) == 0);
      wa  = $urandom_range(0, 7);
      ra1 = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 7);
      ra2 = ($urandom_range(0, 3) == 0) ? ra1 : $urandom_range(0, 7);
      step("rnd", we, wa, 16'($urandom), re1, ra1, re2, ra2, cl);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
